// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC redirect controller.
package pc_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC owner: advances, holds on stalls/imem wait, takes EX redirects,
// and drives IF/ID and ID/EX stall/flush controls plus stall/redirect counters.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             load_use,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      PC_F,
  output logic             fetch_valid,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_pend_target;
  logic [31:0] w_pend_next;
  logic [31:0] w_aligned;
  logic        w_stall_inc;
  logic        w_redirect_inc;

  always_comb begin
    w_aligned      = {redirect_target[31:2], 2'b00};
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_pend_next    = r_pend_target;
    w_stall_inc    = 1'b0;
    w_redirect_inc = 1'b0;
    imem_req       = !rst;
    fetch_valid    = 1'b0;
    stall_F        = 1'b0;
    stall_D        = 1'b0;
    flush_D        = 1'b0;
    flush_E        = 1'b0;
    misalign       = 1'b0;

    if (!rst) begin
      unique case (r_state)
        RUN: begin
          fetch_valid = imem_ready && !redirect_valid && !load_use;
          if (redirect_valid) begin
            flush_D        = 1'b1;
            flush_E        = 1'b1;
            misalign       = (redirect_target[1:0] != 2'b00);
            w_redirect_inc = 1'b1;
            // PC may only move once the outstanding fetch has been answered
            if (imem_ready) begin
              w_pc_next = w_aligned;
            end else begin
              w_pend_next  = w_aligned;
              w_state_next = PEND;
            end
          end else if (load_use) begin
            stall_F     = 1'b1;
            stall_D     = 1'b1;
            flush_E     = 1'b1;
            w_stall_inc = 1'b1;
          end else if (imem_ready) begin
            w_pc_next = r_pc + 32'(INSTR_BYTES);
          end
        end
        PEND: begin
          flush_D = 1'b1;
          if (redirect_valid) begin
            flush_E        = 1'b1;
            misalign       = (redirect_target[1:0] != 2'b00);
            w_redirect_inc = 1'b1;
            w_pend_next    = w_aligned;
          end else if (load_use) begin
            stall_D     = 1'b1;
            flush_E     = 1'b1;
            w_stall_inc = 1'b1;
          end
          if (imem_ready) begin
            w_pc_next    = redirect_valid ? w_aligned : r_pend_target;
            w_state_next = RUN;
          end
        end
        default: begin
          w_state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_pend_target <= w_pend_next;
    end
  end

  assign PC_F = r_pc;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_redirect_inc),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl; a second instance with 2-bit counters
// shares the stimulus so counter saturation is observed on the same traffic.
module tb_pc_redirect_ctrl;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [5:0]  flags;
    logic        req;
    int          sc;
    int          rc;
  } exp_t;

  localparam logic [5:0] F0  = 6'b000000;
  localparam logic [5:0] FV  = 6'b100000;
  localparam logic [5:0] RD  = 6'b000110;
  localparam logic [5:0] LU  = 6'b011010;
  localparam logic [5:0] PD  = 6'b000100;
  localparam logic [5:0] PLU = 6'b001110;
  localparam logic [5:0] MIS = 6'b000111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        load_use = 1'b0;
  logic        imem_ready = 1'b1;

  logic        imem_req, fetch_valid, stall_F, stall_D, flush_D, flush_E, misalign;
  logic [31:0] PC_F;
  logic [15:0] stall_cnt, redirect_cnt;

  logic        s_imem_req, s_fetch_valid, s_stall_F, s_stall_D, s_flush_D, s_flush_E, s_misalign;
  logic [31:0] s_PC_F;
  logic [1:0]  s_stall_cnt, s_redirect_cnt;

  exp_t sbQ[$];
  int   checkCnt = 0;
  int   passCnt  = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .load_use(load_use), .imem_ready(imem_ready), .imem_req(imem_req), .PC_F(PC_F),
    .fetch_valid(fetch_valid), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .flush_E(flush_E), .misalign(misalign), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  pc_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .load_use(load_use), .imem_ready(imem_ready), .imem_req(s_imem_req), .PC_F(s_PC_F),
    .fetch_valid(s_fetch_valid), .stall_F(s_stall_F), .stall_D(s_stall_D), .flush_D(s_flush_D),
    .flush_E(s_flush_E), .misalign(s_misalign), .stall_cnt(s_stall_cnt), .redirect_cnt(s_redirect_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Monitor: every negedge with a pending expectation, compare the DUT's view of this cycle
  always @(negedge clk) begin
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({e.name, ".pc"}, PC_F, e.pc);
      checkOutput({e.name, ".flags"},
                  32'({fetch_valid, stall_F, stall_D, flush_D, flush_E, misalign}), 32'(e.flags));
      checkOutput({e.name, ".req"}, 32'(imem_req), 32'(e.req));
      checkOutput({e.name, ".stall_cnt"}, 32'(stall_cnt), e.sc);
      checkOutput({e.name, ".redirect_cnt"}, 32'(redirect_cnt), e.rc);
      checkOutput({e.name, ".small_stall_cnt"}, 32'(s_stall_cnt), sat3(e.sc));
      checkOutput({e.name, ".small_redirect_cnt"}, 32'(s_redirect_cnt), sat3(e.rc));
    end
  end

  task automatic applyStimulus(input string name, input logic iRst, input logic iRv,
                               input logic [31:0] iTgt, input logic iLu, input logic iRdy,
                               input logic [31:0] ePc, input logic [5:0] eFlags,
                               input logic eReq, input int eSc, input int eRc);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = iRst;
    redirect_valid  = iRv;
    redirect_target = iTgt;
    load_use        = iLu;
    imem_ready      = iRdy;
    e.name  = name;
    e.pc    = ePc;
    e.flags = eFlags;
    e.req   = eReq;
    e.sc    = eSc;
    e.rc    = eRc;
    sbQ.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //            name       rst rv  target        lu rdy  PC_F          flags req sc  rc
    applyStimulus("reset",   1, 0, 32'h0,        0, 1, 32'h0000_0000, F0,  0,  0,  0);
    applyStimulus("adv0",    0, 0, 32'h0,        0, 1, 32'h0000_0000, FV,  1,  0,  0);
    applyStimulus("adv4",    0, 0, 32'h0,        0, 1, 32'h0000_0004, FV,  1,  0,  0);
    applyStimulus("adv8",    0, 0, 32'h0,        0, 1, 32'h0000_0008, FV,  1,  0,  0);
    applyStimulus("advC",    0, 0, 32'h0,        0, 1, 32'h0000_000C, FV,  1,  0,  0);
    applyStimulus("rd100",   0, 1, 32'h100,      0, 1, 32'h0000_0010, RD,  1,  0,  0);
    applyStimulus("rd2000",  0, 1, 32'h2000,     0, 1, 32'h0000_0100, RD,  1,  0,  1);
    applyStimulus("at2000",  0, 0, 32'h0,        0, 1, 32'h0000_2000, FV,  1,  0,  2);
    applyStimulus("rd40",    0, 1, 32'h40,       0, 1, 32'h0000_2004, RD,  1,  0,  2);
    applyStimulus("lu1",     0, 0, 32'h0,        1, 1, 32'h0000_0040, LU,  1,  0,  3);
    applyStimulus("lu2",     0, 0, 32'h0,        1, 1, 32'h0000_0040, LU,  1,  1,  3);
    applyStimulus("afterLu", 0, 0, 32'h0,        0, 1, 32'h0000_0040, FV,  1,  2,  3);
    applyStimulus("at44",    0, 0, 32'h0,        0, 1, 32'h0000_0044, FV,  1,  2,  3);
    applyStimulus("rd80",    0, 1, 32'h80,       0, 1, 32'h0000_0048, RD,  1,  2,  3);
    applyStimulus("pendIn",  0, 1, 32'h300,      0, 0, 32'h0000_0080, RD,  1,  2,  4);
    applyStimulus("pendW1",  0, 0, 32'h0,        0, 0, 32'h0000_0080, PD,  1,  2,  5);
    applyStimulus("pendW2",  0, 0, 32'h0,        0, 0, 32'h0000_0080, PD,  1,  2,  5);
    applyStimulus("pendRdy", 0, 0, 32'h0,        0, 1, 32'h0000_0080, PD,  1,  2,  5);
    applyStimulus("at300",   0, 0, 32'h0,        0, 1, 32'h0000_0300, FV,  1,  2,  5);
    applyStimulus("misLu",   0, 1, 32'h1006,     1, 1, 32'h0000_0304, MIS, 1,  2,  5);
    applyStimulus("at1004",  0, 0, 32'h0,        0, 1, 32'h0000_1004, FV,  1,  2,  6);
    applyStimulus("pend500", 0, 1, 32'h500,      0, 0, 32'h0000_1008, RD,  1,  2,  6);
    applyStimulus("pend600", 0, 1, 32'h600,      0, 0, 32'h0000_1008, RD,  1,  2,  7);
    applyStimulus("pendLu",  0, 0, 32'h0,        1, 0, 32'h0000_1008, PLU, 1,  2,  8);
    applyStimulus("pendRet", 0, 0, 32'h0,        0, 1, 32'h0000_1008, PD,  1,  3,  8);
    applyStimulus("at600",   0, 0, 32'h0,        0, 1, 32'h0000_0600, FV,  1,  3,  8);
    applyStimulus("rdTop",   0, 1, 32'hFFFF_FFFC, 0, 1, 32'h0000_0604, RD,  1,  3,  8);
    applyStimulus("atTop",   0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, FV,  1,  3,  9);
    applyStimulus("wrap0",   0, 0, 32'h0,        0, 1, 32'h0000_0000, FV,  1,  3,  9);
    applyStimulus("luA",     0, 0, 32'h0,        1, 1, 32'h0000_0004, LU,  1,  3,  9);
    applyStimulus("luB",     0, 0, 32'h0,        1, 1, 32'h0000_0004, LU,  1,  4,  9);
    applyStimulus("luC",     0, 0, 32'h0,        1, 1, 32'h0000_0004, LU,  1,  5,  9);
    applyStimulus("satChk",  0, 0, 32'h0,        0, 1, 32'h0000_0004, FV,  1,  6,  9);
    applyStimulus("pend900", 0, 1, 32'h900,      0, 0, 32'h0000_0008, RD,  1,  6,  9);
    applyStimulus("rstPend", 1, 0, 32'h0,        0, 0, 32'h0000_0008, F0,  0,  6, 10);
    applyStimulus("postRst", 0, 0, 32'h0,        0, 1, 32'h0000_0000, FV,  1,  0,  0);
    applyStimulus("post4",   0, 0, 32'h0,        0, 1, 32'h0000_0004, FV,  1,  0,  0);
    @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
